// File: rtl/bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_pkg                                                                  |
// | Shared bus geometry, source index map and word type for the datapath.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package bus_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int BUS_NSRC  = 24;

  localparam int SRC_R0   = 0;
  localparam int SRC_R1   = 1;
  localparam int SRC_R2   = 2;
  localparam int SRC_R3   = 3;
  localparam int SRC_R4   = 4;
  localparam int SRC_R5   = 5;
  localparam int SRC_R6   = 6;
  localparam int SRC_R7   = 7;
  localparam int SRC_R8   = 8;
  localparam int SRC_R9   = 9;
  localparam int SRC_R10  = 10;
  localparam int SRC_R11  = 11;
  localparam int SRC_R12  = 12;
  localparam int SRC_R13  = 13;
  localparam int SRC_R14  = 14;
  localparam int SRC_R15  = 15;
  localparam int SRC_HI   = 16;
  localparam int SRC_LO   = 17;
  localparam int SRC_ZHI  = 18;
  localparam int SRC_ZLO  = 19;
  localparam int SRC_PC   = 20;
  localparam int SRC_MDR  = 21;
  localparam int SRC_PORT = 22;
  localparam int SRC_CSE  = 23;

  typedef logic [BUS_WIDTH-1:0] bus_word_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter                                                               |
// | Combinational rotating-priority arbiter: first requester at/after ptr.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NSRC  = 24,
  parameter int IDX_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NSRC-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned pos;

  // With ptr = 0 this degenerates to a plain lowest-index priority encoder.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NSRC; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NSRC) pos = pos - NSRC;
      if (!any && req[IDX_W'(pos)]) begin
        any              = 1'b1;
        gnt[IDX_W'(pos)] = 1'b1;
        idx              = IDX_W'(pos);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bus_mux_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_mux_reg                                                              |
// | Registered NSRC:1 bus multiplexer with multi-select detection and        |
// | optional round-robin arbitration. Revision: 1.0                          |
// +--------------------------------------------------------------------------+
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int NSRC  = BUS_NSRC,
  parameter int IDX_W = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_out,
  input  logic                  arb_en,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic [NSRC-1:0]       grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  multi_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSRC - 1);

  logic [WIDTH-1:0] words [NSRC];
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] arb_ptr;
  logic [NSRC-1:0]  sel_gnt;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             multi_sel;

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign words[i] = src_data[i*WIDTH +: WIDTH];
  end

  // Direct mode uses the same arbiter anchored at index 0.
  assign arb_ptr   = arb_en ? rr_ptr : '0;
  assign multi_sel = !arb_en && ((src_out & (src_out - 1'b1)) != '0);

  rr_arbiter #(
    .NSRC  (NSRC),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (src_out),
    .ptr (arb_ptr),
    .gnt (sel_gnt),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
      grant     <= '0;
      grant_idx <= '0;
      multi_err <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      bus_valid <= sel_any;
      grant     <= sel_gnt;
      if (sel_any) begin
        bus_out   <= words[sel_idx];
        grant_idx <= sel_idx;
        if (arb_en) rr_ptr <= (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
      end
      if (multi_sel)    multi_err <= 1'b1;
      else if (err_clr) multi_err <= 1'b0;
    end
  end

endmodule : bus_mux_reg
`default_nettype wire

// File: tb/tb_bus_mux_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bus_mux_reg                                                           |
// | Directed self-checking bench for bus_mux_reg. Revision: 1.0              |
// +--------------------------------------------------------------------------+
module tb_bus_mux_reg;
  import bus_pkg::*;

  localparam int WIDTH = BUS_WIDTH;
  localparam int NSRC  = BUS_NSRC;
  localparam int IDX_W = $clog2(NSRC);

  logic                  clk = 1'b0;
  logic                  clear;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  arb_en;
  logic                  err_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [NSRC-1:0]       grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  multi_err;

  int checks = 0;
  int errors = 0;

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .clear     (clear),
    .src_data  (src_data),
    .src_out   (src_out),
    .arb_en    (arb_en),
    .err_clr   (err_clr),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  function automatic bus_word_t word_of(input int i);
    if (i == SRC_R1) return 32'h0000_1111;
    if (i == SRC_R2) return 32'h1111_0000;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic logic [NSRC-1:0] bit_of(input int i);
    logic [NSRC-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; src_out = '0; arb_en = 1'b0; err_clr = 1'b0;
    step(); step();
    checks++;
    if ({bus_out, bus_valid, grant, grant_idx, multi_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: bus=%h valid=%b grant=%h idx=%0d err=%b, expected all zero",
               bus_out, bus_valid, grant, grant_idx, multi_err);
    end
    clear = 1'b0;
    step();
    checks++;
    if (bus_out !== 32'h0 || bus_valid !== 1'b0 || grant !== '0 || multi_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: bus=%h valid=%b grant=%h err=%b, expected 0/0/0/0",
               bus_out, bus_valid, grant, multi_err);
    end
  endtask

  task automatic test_direct();
    int sel [2] = '{SRC_R1, SRC_R2};
    foreach (sel[k]) begin
      src_out = bit_of(sel[k]);
      step();
      checks++;
      if (bus_out !== word_of(sel[k]) || grant_idx !== IDX_W'(sel[k]) ||
          grant !== bit_of(sel[k]) || bus_valid !== 1'b1) begin
        errors++;
        $display("FAIL direct_sel%0d: bus=%h idx=%0d grant=%h valid=%b, expected bus=%h idx=%0d",
                 sel[k], bus_out, grant_idx, grant, bus_valid, word_of(sel[k]), sel[k]);
      end
    end
    src_out = '0;
    step();
    checks++;
    if (bus_out !== 32'h1111_0000 || bus_valid !== 1'b0 || grant !== '0 || grant_idx !== IDX_W'(2)) begin
      errors++;
      $display("FAIL direct_hold: bus=%h valid=%b grant=%h idx=%0d, expected 11110000/0/0/2",
               bus_out, bus_valid, grant, grant_idx);
    end
  endtask

  task automatic test_multi();
    src_out = bit_of(SRC_R1) | bit_of(SRC_R2);
    step();
    checks++;
    if (bus_out !== 32'h0000_1111 || grant_idx !== IDX_W'(1) || multi_err !== 1'b1 || bus_valid !== 1'b1) begin
      errors++;
      $display("FAIL multi_select: bus=%h idx=%0d err=%b valid=%b, expected 00001111/1/1/1",
               bus_out, grant_idx, multi_err, bus_valid);
    end
    err_clr = 1'b1;
    step();
    checks++;
    if (multi_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_set_wins: err=%b, expected 1", multi_err);
    end
    src_out = bit_of(SRC_R2);
    step();
    checks++;
    if (multi_err !== 1'b0 || bus_out !== 32'h1111_0000) begin
      errors++;
      $display("FAIL multi_clear: err=%b bus=%h, expected 0/11110000", multi_err, bus_out);
    end
    err_clr = 1'b0;
    src_out = '0;
    step();
  endtask

  task automatic test_round_robin();
    int exp [4] = '{SRC_R3, SRC_PC, SRC_CSE, SRC_R3};
    arb_en  = 1'b1;
    src_out = bit_of(SRC_R3) | bit_of(SRC_PC) | bit_of(SRC_CSE);
    foreach (exp[k]) begin
      step();
      checks++;
      if (grant_idx !== IDX_W'(exp[k]) || grant !== bit_of(exp[k]) ||
          bus_out !== word_of(exp[k]) || multi_err !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant%0d: idx=%0d bus=%h err=%b, expected idx=%0d bus=%h err=0",
                 k, grant_idx, bus_out, multi_err, exp[k], word_of(exp[k]));
      end
    end
  endtask

  task automatic test_mid_reset();
    step();
    checks++;
    if (grant_idx !== IDX_W'(SRC_PC)) begin
      errors++;
      $display("FAIL mid_pre_grant: idx=%0d, expected %0d", grant_idx, SRC_PC);
    end
    clear = 1'b1;
    step();
    checks++;
    if ({bus_out, bus_valid, grant, grant_idx, multi_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset: bus=%h valid=%b grant=%h idx=%0d, expected all zero",
               bus_out, bus_valid, grant, grant_idx);
    end
    clear = 1'b0;
    step();
    checks++;
    if (grant_idx !== IDX_W'(SRC_R3) || bus_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_post_grant: idx=%0d valid=%b, expected 3/1", grant_idx, bus_valid);
    end
    step();
    checks++;
    if (grant_idx !== IDX_W'(SRC_PC)) begin
      errors++;
      $display("FAIL mid_next_grant: idx=%0d, expected %0d", grant_idx, SRC_PC);
    end
  endtask

  task automatic test_mode_switch();
    arb_en  = 1'b0;
    src_out = bit_of(SRC_R5);
    step();
    checks++;
    if (grant_idx !== IDX_W'(SRC_R5) || bus_out !== word_of(SRC_R5)) begin
      errors++;
      $display("FAIL switch_direct: idx=%0d bus=%h, expected 5/%h", grant_idx, bus_out, word_of(SRC_R5));
    end
    arb_en  = 1'b1;
    src_out = bit_of(SRC_R5) | bit_of(SRC_PORT);
    step();
    checks++;
    if (grant_idx !== IDX_W'(SRC_PORT) || bus_out !== word_of(SRC_PORT)) begin
      errors++;
      $display("FAIL switch_retain: idx=%0d bus=%h, expected 22/%h", grant_idx, bus_out, word_of(SRC_PORT));
    end
    step();
    checks++;
    if (grant_idx !== IDX_W'(SRC_R5)) begin
      errors++;
      $display("FAIL switch_wrap: idx=%0d, expected 5", grant_idx);
    end
    src_out = '0;
    step();
    checks++;
    if (bus_valid !== 1'b0 || grant !== '0 || grant_idx !== IDX_W'(SRC_R5) || bus_out !== word_of(SRC_R5)) begin
      errors++;
      $display("FAIL arb_idle: valid=%b grant=%h idx=%0d bus=%h, expected 0/0/5/%h",
               bus_valid, grant, grant_idx, bus_out, word_of(SRC_R5));
    end
  endtask

  initial begin
    for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = word_of(i);
    clear = 1'b1; src_out = '0; arb_en = 1'b0; err_clr = 1'b0;
    test_reset();
    test_direct();
    test_multi();
    test_round_robin();
    test_mid_reset();
    test_mode_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bus_mux_reg
`default_nettype wire
